// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory/IO interface.
package lc3_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StRel
    } mem_state_e;

    localparam logic [15:0] ADDR_KBSR        = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR        = 16'hFE02;
    localparam logic [15:0] ADDR_DSR         = 16'hFE04;
    localparam logic [15:0] ADDR_DDR         = 16'hFE06;
    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

    function automatic logic is_dev_addr(input logic [15:0] addr);
        return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) ||
               (addr == ADDR_DSR)  || (addr == ADDR_DDR);
    endfunction

endpackage

// File: rtl/lc3_dev_regs.sv
// Memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR) registers with their handshakes.
module lc3_dev_regs
    import lc3_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_kb_strobe,
    input  logic [7:0]  i_kb_data,
    input  logic        i_dsp_ack,
    output logic [15:0] o_rdata,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data
);

    logic        r_kb_ready;
    logic        r_kb_ovr;
    logic [15:0] r_kbdr;
    logic        r_dsp_ready;
    logic        r_dsp_valid;
    logic [15:0] r_ddr;

    logic w_rd_kbsr;
    logic w_rd_kbdr;
    logic w_wr_ddr;

    assign w_rd_kbsr = i_rd && (i_addr == ADDR_KBSR);
    assign w_rd_kbdr = i_rd && (i_addr == ADDR_KBDR);
    assign w_wr_ddr  = i_wr && (i_addr == ADDR_DDR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_kb_ready  <= 1'b0;
            r_kb_ovr    <= 1'b0;
            r_kbdr      <= 16'h0000;
            r_dsp_ready <= 1'b1;
            r_dsp_valid <= 1'b0;
            r_ddr       <= 16'h0000;
        end else begin
            // A new strobe beats a concurrent KBDR read, so the fresh character stays flagged
            if (i_kb_strobe) begin
                r_kbdr     <= {8'h00, i_kb_data};
                r_kb_ready <= 1'b1;
            end else if (w_rd_kbdr) begin
                r_kb_ready <= 1'b0;
            end
            if (i_kb_strobe && r_kb_ready) begin
                r_kb_ovr <= 1'b1;
            end else if (w_rd_kbsr) begin
                r_kb_ovr <= 1'b0;
            end
            if (w_wr_ddr) begin
                r_ddr       <= i_wdata;
                r_dsp_ready <= 1'b0;
                r_dsp_valid <= 1'b1;
            end else if (i_dsp_ack) begin
                r_dsp_ready <= 1'b1;
                r_dsp_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rdata = 16'h0000;
        case (i_addr)
            ADDR_KBSR: o_rdata = {r_kb_ready, r_kb_ovr, 14'h0000};
            ADDR_KBDR: o_rdata = r_kbdr;
            ADDR_DSR:  o_rdata = {r_dsp_ready, 15'h0000};
            ADDR_DDR:  o_rdata = r_ddr;
            default:   o_rdata = 16'h0000;
        endcase
    end

    assign o_dsp_valid = r_dsp_valid;
    assign o_dsp_data  = r_ddr[7:0];

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR and access sequencer: internal device registers or external req/ack memory.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [15:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld_mar,
    input  logic        i_ld_mdr,
    input  logic        i_mio_en,
    input  logic        i_r_w,
    input  logic        i_gate_mdr,
    input  logic [15:0] i_data_bus,
    output logic [15:0] o_mdr_out,
    output logic        o_mem_r,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    input  logic        i_kb_strobe,
    input  logic [7:0]  i_kb_data,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data,
    input  logic        i_dsp_ack
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    mem_state_e    r_state;
    mem_state_e    w_state_d;
    logic [15:0]   r_mar;
    logic [15:0]   r_mdr;
    logic          r_we;
    logic          r_bus_err;
    logic [CntW-1:0] r_tmo_cnt;

    logic          w_is_dev;
    logic          w_tmo;
    logic          w_dev_rd;
    logic          w_dev_wr;
    logic [15:0]   w_dev_rdata;

    assign w_is_dev = is_dev_addr(r_mar);
    assign w_tmo    = (r_tmo_cnt == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_d = r_state;
        w_dev_rd  = 1'b0;
        w_dev_wr  = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_mio_en) begin
                    if (w_is_dev) begin
                        w_dev_rd  = !i_r_w;
                        w_dev_wr  = i_r_w;
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StReq;
                    end
                end
            end
            StReq:   if (i_mem_ack || w_tmo) w_state_d = StDone;
            StDone:  w_state_d = StRel;
            StRel:   if (!i_mio_en) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_mar     <= 16'h0000;
            r_mdr     <= 16'h0000;
            r_we      <= 1'b0;
            r_bus_err <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (i_ld_mar) r_mar <= i_data_bus;
            if (w_dev_rd) begin
                r_mdr <= w_dev_rdata;
            end else if (r_state == StReq && !r_we && i_mem_ack) begin
                r_mdr <= i_mem_rdata;
            end else if (r_state == StReq && !r_we && w_tmo) begin
                r_mdr <= ERR_DATA;
            end else if (i_ld_mdr && !i_mio_en) begin
                r_mdr <= i_data_bus;
            end
            // Direction is captured on the way out of IDLE and held for the whole request
            if (r_state == StIdle) r_we <= i_r_w;
            r_tmo_cnt <= (r_state == StReq) ? r_tmo_cnt + 1'b1 : '0;
            if (r_state == StReq && !i_mem_ack && w_tmo) r_bus_err <= 1'b1;
        end
    end

    lc3_dev_regs u_dev_regs (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd        (w_dev_rd),
        .i_wr        (w_dev_wr),
        .i_addr      (r_mar),
        .i_wdata     (r_mdr),
        .i_kb_strobe (i_kb_strobe),
        .i_kb_data   (i_kb_data),
        .i_dsp_ack   (i_dsp_ack),
        .o_rdata     (w_dev_rdata),
        .o_dsp_valid (o_dsp_valid),
        .o_dsp_data  (o_dsp_data)
    );

    assign o_mdr_out   = i_gate_mdr ? r_mdr : 16'h0000;
    assign o_mem_r     = (r_state == StDone);
    assign o_bus_err   = r_bus_err;
    assign o_mem_req   = (r_state == StReq);
    assign o_mem_we    = (r_state == StReq) && r_we;
    assign o_mem_addr  = r_mar;
    assign o_mem_wdata = r_mdr;

endmodule
